// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC sequencing, imem req/ack fetch and valid/ready hand-off to decode
module pc_fetch_ctrl #(
    parameter int                 ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_address,
    output logic [ADDR_W-1:0] next_address,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic              misalign_err
);
    typedef enum logic [1:0] {RST_WAIT, FETCH, FLUSH, HOLD} state_t;
    state_t            state_q, state_d;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] instr_pc_q, flush_addr_q;
    logic              misalign_q, misalign_d;
    logic              redir, capture, go_flush;
    logic [ADDR_W-1:0] sel_target, target, pc_plus4;
    assign redir      = branch_taken | jump;
    assign sel_target = branch_taken ? branch_target : jump_target;
    assign target     = {sel_target[ADDR_W-1:2], 2'b00};
    assign pc_plus4   = pc_address + ADDR_W'(4);
    assign capture    = (state_q == FETCH) & imem_ack & ~redir;
    assign go_flush   = (state_q == FETCH) & ~imem_ack & redir;
    // redirects are ignored in RST_WAIT, so only applied ones can flag misalignment
    assign misalign_d = redir & (state_q != RST_WAIT) & (sel_target[1:0] != 2'b00);
    // state register; reset drops imem_req immediately by forcing RST_WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RST_WAIT;
        else     state_q <= state_d;
    end
    // next-state: a redirect in FETCH without ack must drain the stale request in FLUSH
    always_comb begin
        state_d = state_q;
        case (state_q)
            RST_WAIT: state_d = FETCH;
            FETCH:    state_d = redir ? (imem_ack ? FETCH : FLUSH) : (imem_ack ? HOLD : FETCH);
            FLUSH:    state_d = imem_ack ? FETCH : FLUSH;
            HOLD:     state_d = (redir | instr_ready) ? FETCH : HOLD;
            default:  state_d = RST_WAIT;
        endcase
    end
    // outputs: the latest redirect always wins the PC, otherwise advance only on a kept fetch
    always_comb begin
        imem_req     = (state_q == FETCH) | (state_q == FLUSH);
        imem_addr    = (state_q == FLUSH) ? flush_addr_q : pc_address;
        instr_valid  = (state_q == HOLD);
        next_address = (state_q == RST_WAIT) ? RESET_ADDR :
                       redir                 ? target :
                       capture               ? pc_plus4 : pc_address;
    end
    // datapath registers: captured instruction, stale fetch address, misalign pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q      <= '0;
            instr_pc_q   <= '0;
            flush_addr_q <= '0;
            misalign_q   <= 1'b0;
        end else begin
            if (capture) begin
                instr_q    <= imem_rdata;
                instr_pc_q <= pc_address;
            end
            if (go_flush) flush_addr_q <= pc_address;
            misalign_q <= misalign_d;
        end
    end
    assign instr        = instr_q;
    assign instr_pc     = instr_pc_q;
    assign misalign_err = misalign_q;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: randomized scoreboard bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;
    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_address = '0;
    logic [31:0] next_address, imem_addr, instr, instr_pc;
    logic        imem_req, instr_valid, misalign_err;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_ready = 1'b0;
    logic        branch_taken = 1'b0, jump = 1'b0;
    logic [31:0] branch_target = '0, jump_target = '0;
    int          checks = 0, errors = 0, accepts = 0;
    bit          redir_ok = 1'b0;
    bit          did_rst = 1'b0;
    logic [31:0] exp_q[$];

    pc_fetch_ctrl #(.ADDR_W(32), .RESET_ADDR(RESET_ADDR)) dut (
        .clk(clk), .rst(rst), .pc_address(pc_address), .next_address(next_address),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    // external PC register
    always @(posedge clk) pc_address <= next_address;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0100;
            1: return 32'h0000_0203;
            2: return 32'hFFFF_FFFC;
            3: return 32'hFFFF_FFFE;
            4: return $urandom & 32'hFFFF_FFFC;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // instruction memory: random latency, random acks even without a request
    initial forever begin
        @(negedge clk);
        imem_ack   = ($urandom_range(0, 2) == 0);
        imem_rdata = (imem_ack && imem_req) ? mem_word(imem_addr) : $urandom;
    end

    // monitor: samples just before each rising edge with inputs settled
    initial begin
        bit          pend_mis = 1'b0, prev_wait = 1'b0, redir;
        logic [31:0] prev_addr = '0, sel, e;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                pend_mis  = 1'b0;
                prev_wait = 1'b0;
            end else begin
                check("misalign_err", 32'(misalign_err), 32'(pend_mis));
                redir    = redir_ok && (branch_taken || jump);
                sel      = branch_taken ? branch_target : jump_target;
                pend_mis = redir && (sel[1:0] != 2'b00);
                if (instr_valid) check("req_in_hold", 32'(imem_req), 32'd0);
                if (prev_wait) check("req_addr_stable", {imem_req, imem_addr[30:0]}, {1'b1, prev_addr[30:0]});
                prev_wait = imem_req && !imem_ack;
                prev_addr = imem_addr;
                if (instr_valid && instr_ready && !redir) begin
                    accepts++;
                    if (exp_q.size() == 0) begin
                        check("scoreboard_nonempty", 32'd0, 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("instr_pc", instr_pc, e);
                        check("instr", instr, mem_word(e));
                        exp_q.push_back(e + 32'd4);
                    end
                end
            end
        end
    end

    // stimulus
    initial begin
        exp_q.push_back(RESET_ADDR);
        repeat (3) @(negedge clk);
        check("rst_next_address", next_address, RESET_ADDR);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_misalign", 32'(misalign_err), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            redir_ok      = 1'b1;
            instr_ready   = ($urandom_range(0, 3) != 0);
            branch_target = pick_target();
            jump_target   = pick_target();
            if ($urandom_range(0, 7) == 0) begin
                branch_taken = $urandom_range(0, 1);
                jump         = !branch_taken || ($urandom_range(0, 1) == 1);
                exp_q.delete();
                exp_q.push_back((branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC);
            end else begin
                branch_taken = 1'b0;
                jump         = 1'b0;
            end
            if (i >= 1500 && !did_rst && imem_req) begin
                #2 rst = 1'b1;
                #1;
                check("midrst_imem_req", 32'(imem_req), 32'd0);
                check("midrst_instr_valid", 32'(instr_valid), 32'd0);
                check("midrst_next_address", next_address, RESET_ADDR);
                check("midrst_misalign", 32'(misalign_err), 32'd0);
                branch_taken = 1'b0;
                jump         = 1'b0;
                redir_ok     = 1'b0;
                exp_q.delete();
                exp_q.push_back(RESET_ADDR);
                repeat (2) @(negedge clk);
                rst     = 1'b0;
                did_rst = 1'b1;
            end
        end
        @(negedge clk);
        branch_taken = 1'b0;
        jump         = 1'b0;
        check("mid_reset_taken", 32'(did_rst), 32'd1);
        check("accept_count_min", 32'(accepts >= 100), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
